gcd_lcm_sched: RTL and testbench
================================

// Module: gcd_lcm_sched
// PURPOSE
//  Shares one GCD_LCM engine among NREQ requesters using round-robin arbitration.
//  Each requester presents an operand pair (a, b) and holds a request.
//  The scheduler latches the pair and streams it into the engine: a with start,
//  then b on the next cycle. It waits for done and returns gcd/lcm with the
//  requester ID. Sits between client blocks and the single GCD_LCM instance.
// PARAMETERS
//  SIZE     8   operand / gcd width; lcm width is 2*SIZE+1
//  NREQ     4   number of requesters (>=2); IDW = $clog2(NREQ)
//  TIMEOUT  64  max cycles in WAIT before the op is aborted with error
// PORTS
//  clk       in   1            rising-edge clock
//  rst_n     in   1            asynchronous reset, active low
//  req       in   NREQ         per-requester request level
//  req_a     in   NREQ*SIZE    operand a, slice i for requester i
//  req_b     in   NREQ*SIZE    operand b, slice i for requester i
//  req_ack   out  NREQ         one-hot, 1-cycle pulse: operands captured
//  eng_start out  1            to engine start
//  eng_data  out  SIZE         to engine data_in
//  eng_done  in   1            from engine done (pulse or level accepted)
//  eng_gcd   in   SIZE         from engine gcd
//  eng_lcm   in   2*SIZE+1     from engine lcm
//  rsp_valid out  1            1-cycle pulse, response fields valid
//  rsp_id    out  IDW          requester index of response
//  rsp_gcd   out  SIZE         result gcd (0 on error)
//  rsp_lcm   out  2*SIZE+1     result lcm (0 on error)
//  rsp_err   out  1            zero operand or engine timeout
//  busy      out  1            high in every state except IDLE
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; rr pointer 0; timeout counter 0.
//  - All outputs are registered. Engine data path widths are unchanged; no arithmetic in this block.
//  - FSM: IDLE -> LOAD_A -> LOAD_B -> WAIT -> RESP -> IDLE.
//    Zero-operand path: IDLE -> RESP directly.
//  - IDLE, at an edge with req != 0:
//    - grant the first set req bit searching from ptr upward, with wrap.
//    - latch id, a and b; req_ack[id] = 1 for the next cycle only.
//    - if a == 0 or b == 0: go to RESP with err = 1; the engine is untouched.
//    - otherwise go to LOAD_A.
//  - LOAD_A, 1 cycle: eng_start = 1, eng_data = a.
//  - LOAD_B, 1 cycle: eng_start = 0, eng_data = b. eng_data holds b through WAIT.
//  - WAIT: completion = eng_done high AND eng_done has been seen low since LOAD_A
//    (seen_low flag). This rejects a stale level done.
//    - On completion: capture eng_gcd / eng_lcm, go to RESP.
//    - The counter increments each WAIT cycle. On reaching TIMEOUT with no
//      completion: go to RESP with err = 1, gcd = lcm = 0.
//  - RESP, 1 cycle: rsp_valid = 1 with id / gcd / lcm / err. ptr <= id+1 (mod NREQ).
//    Then IDLE; counter and seen_low clear.
//  - Requester rules:
//    - hold req and operands stable until ack; drop req the cycle after ack.
//    - req is ignored outside IDLE, so a late drop causes no double grant
//      within the same op.
//    - a req still high when back in IDLE is a new request.
//  - Latency, no contention, normal path: ack 1 cycle after req sampled.
//    eng_start 1 cycle after the IDLE edge. rsp_valid = engine latency + 3 cycles
//    after the first engine cycle.
//  - Simultaneous requests: strictly rotating priority; no requester is skipped
//    twice in a row.
//  - Reset mid-operation: immediate return to reset state. The in-flight op is
//    dropped; no rsp is issued.
// TESTING
//  1. req[0], a=100, b=20 -> ack[0]. eng_start=1 with data 100 for 1 cycle, then
//     data 20. The model asserts done -> rsp id=0 gcd=20 lcm=100 err=0.
//  2. req=4'b1111 after reset (each pair 12,18) -> rsp ids in order 0,1,2,3.
//     Then req=4'b0101 with ptr=0 -> ids 0 then 2, each gcd=6 lcm=36.
//  3. req[1], a=0, b=7 -> ack[1]; rsp err=1 gcd=0 lcm=0 within 3 cycles.
//     eng_start never asserted.
//  4. Engine model never raises done -> rsp err=1 after 64 WAIT cycles.
//     A following req[2] a=9 b=6 -> gcd=3 lcm=18.
//  5. Done held high from the prior op, low for 2 cycles, then high -> results
//     captured only on the re-rise; no early rsp_valid.
//  6. rst_n low during WAIT -> busy=0 and all outputs 0 immediately.
//     After release, req[3] a=8 b=12 -> gcd=4 lcm=24, id=3.

Source files
------------

// File: rtl/gcd_lcm_sched.sv
// Round-robin front end for a single shared GCD/LCM engine: grants one requester,
// streams its operand pair into the engine, and returns the result tagged with the requester id.
module gcd_lcm_sched #(
  parameter int SIZE    = 8,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64,
  localparam int IDW    = $clog2(NREQ),
  localparam int LW     = 2*SIZE+1,
  localparam int CW     = $clog2(TIMEOUT+1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*SIZE-1:0] req_a,
  input  logic [NREQ*SIZE-1:0] req_b,
  output logic [NREQ-1:0]      req_ack,
  output logic                 eng_start,
  output logic [SIZE-1:0]      eng_data,
  input  logic                 eng_done,
  input  logic [SIZE-1:0]      eng_gcd,
  input  logic [LW-1:0]        eng_lcm,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [SIZE-1:0]      rsp_gcd,
  output logic [LW-1:0]        rsp_lcm,
  output logic                 rsp_err,
  output logic                 busy
);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, WAIT, RESP} state_t;

  typedef struct packed {
    logic [IDW-1:0]  id;
    logic [SIZE-1:0] gcd;
    logic [LW-1:0]   lcm;
    logic            err;
  } rsp_t;

  logic [NREQ-1:0][SIZE-1:0] opa_v, opb_v;
  assign opa_v = req_a;
  assign opb_v = req_b;

  state_t          state, state_d;
  logic [IDW-1:0]  ptr, ptr_d, id, id_d, gnt_id;
  logic [SIZE-1:0] op_a, op_a_d, op_b, op_b_d, data_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic            seen_low, seen_d, start_d, vld_d, gnt_found;
  logic [NREQ-1:0] ack_d;
  rsp_t            rsp_q, rsp_d;
  logic [IDW:0]    sum;

  // rotating search: first set req bit at or above ptr, wrapping
  always_comb begin
    gnt_id    = '0;
    gnt_found = 1'b0;
    sum       = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
      if (!gnt_found && req[sum[IDW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_id    = sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    id_d    = id;
    op_a_d  = op_a;
    op_b_d  = op_b;
    cnt_d   = cnt;
    seen_d  = seen_low;
    ack_d   = '0;
    start_d = 1'b0;
    data_d  = eng_data;
    vld_d   = 1'b0;
    rsp_d   = rsp_q;
    case (state)
      IDLE: begin
        cnt_d  = '0;
        seen_d = 1'b0;
        if (gnt_found) begin
          id_d          = gnt_id;
          op_a_d        = opa_v[gnt_id];
          op_b_d        = opb_v[gnt_id];
          ack_d[gnt_id] = 1'b1;
          if (opa_v[gnt_id] == '0 || opb_v[gnt_id] == '0) begin
            state_d = RESP;
            vld_d   = 1'b1;
            rsp_d   = '{id: gnt_id, gcd: '0, lcm: '0, err: 1'b1};
          end else begin
            state_d = LOAD_A;
            start_d = 1'b1;
            data_d  = opa_v[gnt_id];
          end
        end
      end
      LOAD_A: begin
        state_d = LOAD_B;
        data_d  = op_b;
        seen_d  = seen_low | ~eng_done;
      end
      LOAD_B: begin
        state_d = WAIT;
        seen_d  = seen_low | ~eng_done;
      end
      WAIT: begin
        seen_d = seen_low | ~eng_done;
        cnt_d  = cnt + 1'b1;
        // a done level left over from the previous op only counts after it has dropped
        if (eng_done && seen_low) begin
          state_d = RESP;
          vld_d   = 1'b1;
          rsp_d   = '{id: id, gcd: eng_gcd, lcm: eng_lcm, err: 1'b0};
        end else if (cnt == CW'(TIMEOUT-1)) begin
          state_d = RESP;
          vld_d   = 1'b1;
          rsp_d   = '{id: id, gcd: '0, lcm: '0, err: 1'b1};
        end
      end
      RESP: begin
        state_d = IDLE;
        ptr_d   = (id == IDW'(NREQ-1)) ? '0 : id + 1'b1;
        cnt_d   = '0;
        seen_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      id        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      cnt       <= '0;
      seen_low  <= 1'b0;
      req_ack   <= '0;
      eng_start <= 1'b0;
      eng_data  <= '0;
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      id        <= id_d;
      op_a      <= op_a_d;
      op_b      <= op_b_d;
      cnt       <= cnt_d;
      seen_low  <= seen_d;
      req_ack   <= ack_d;
      eng_start <= start_d;
      eng_data  <= data_d;
      rsp_valid <= vld_d;
      rsp_q     <= rsp_d;
      busy      <= (state_d != IDLE);
    end
  end

  assign rsp_id  = rsp_q.id;
  assign rsp_gcd = rsp_q.gcd;
  assign rsp_lcm = rsp_q.lcm;
  assign rsp_err = rsp_q.err;

endmodule

// File: tb/tb_gcd_lcm_sched.sv
// Directed bench for gcd_lcm_sched with a small behavioural engine (pulse, silent, level-done modes).
module tb_gcd_lcm_sched;
  localparam int SIZE = 8;
  localparam int NREQ = 4;
  localparam int LW   = 2*SIZE+1;

  logic                 gclk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req;
  logic [NREQ*SIZE-1:0] req_a, req_b;
  logic [NREQ-1:0]      req_ack;
  logic                 eng_start;
  logic [SIZE-1:0]      eng_data;
  logic                 eng_done = 1'b0;
  logic [SIZE-1:0]      eng_gcd  = '0;
  logic [LW-1:0]        eng_lcm  = '0;
  logic                 rsp_valid;
  logic [1:0]           rsp_id;
  logic [SIZE-1:0]      rsp_gcd;
  logic [LW-1:0]        rsp_lcm;
  logic                 rsp_err;
  logic                 busy;

  always #5 gclk = ~gclk;

  gcd_lcm_sched #(.SIZE(SIZE), .NREQ(NREQ), .TIMEOUT(64)) dut (
    .clk(gclk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
    .req_ack(req_ack), .eng_start(eng_start), .eng_data(eng_data),
    .eng_done(eng_done), .eng_gcd(eng_gcd), .eng_lcm(eng_lcm),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_gcd(rsp_gcd),
    .rsp_lcm(rsp_lcm), .rsp_err(rsp_err), .busy(busy)
  );

  // engine: mode 0 pulses done one WAIT cycle in, mode 1 never finishes,
  // mode 2 drops done for two cycles then raises and holds it as a level
  int mode = 0;
  int ecnt = 0;
  logic [SIZE-1:0] ea = '0, eb = '0;

  function automatic logic [SIZE-1:0] gcd_f(input logic [SIZE-1:0] x, input logic [SIZE-1:0] y);
    logic [SIZE-1:0] p, q, t;
    p = x; q = y;
    while (q != 0) begin t = p % q; p = q; q = t; end
    return p;
  endfunction

  function automatic logic [LW-1:0] lcm_f(input logic [SIZE-1:0] x, input logic [SIZE-1:0] y);
    logic [LW-1:0] g;
    g = LW'(gcd_f(x, y));
    return (LW'(x) * LW'(y)) / g;
  endfunction

  always @(posedge gclk) begin
    if (mode == 0 && eng_done) eng_done <= 1'b0;
    if (eng_start) begin
      ea <= eng_data; ecnt <= 1;
    end else if (ecnt == 1) begin
      eb <= eng_data; ecnt <= 2;
    end else if (ecnt >= 2) begin
      ecnt <= ecnt + 1;
      if (mode == 2 && ecnt == 2) eng_done <= 1'b0;
      if ((mode == 0 && ecnt == 2) || (mode == 2 && ecnt == 4)) begin
        eng_done <= 1'b1;
        eng_gcd  <= gcd_f(ea, eb);
        eng_lcm  <= lcm_f(ea, eb);
        ecnt     <= 0;
      end
    end
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  int r_id[8], r_gcd[8], r_lcm[8], r_err[8], r_lat[8];
  int ack_c[NREQ];
  int n_rsp, st_cnt, d_a, d_b;

  // drive mask with the same pair on every slot; collect nexp responses
  task automatic run(input logic [3:0] mask, input logic [7:0] a, input logic [7:0] b, input int nexp);
    logic prev_st;
    @(negedge gclk);
    req_a = {NREQ{a}}; req_b = {NREQ{b}}; req = mask;
    n_rsp = 0; st_cnt = 0; prev_st = 1'b0; d_a = -1; d_b = -1;
    for (int i = 0; i < NREQ; i++) ack_c[i] = 0;
    for (int c = 1; c <= 400 && n_rsp < nexp; c++) begin
      @(negedge gclk);
      if (prev_st) d_b = int'(eng_data);
      prev_st = eng_start;
      if (eng_start) begin st_cnt++; d_a = int'(eng_data); end
      if (|req_ack) chk("ack_onehot", 32'($countones(req_ack)), 32'd1);
      for (int i = 0; i < NREQ; i++)
        if (req_ack[i]) begin ack_c[i] = c; req[i] = 1'b0; end
      if (rsp_valid && n_rsp < 8) begin
        r_id[n_rsp]  = int'(rsp_id);
        r_gcd[n_rsp] = int'(rsp_gcd);
        r_lcm[n_rsp] = int'(rsp_lcm);
        r_err[n_rsp] = int'(rsp_err);
        r_lat[n_rsp] = c - ack_c[rsp_id];
        n_rsp++;
      end
    end
    chk("rsp_count", 32'(n_rsp), 32'(nexp));
    req = '0;
  endtask

  task automatic chk_rsp(input string tag, input int k, input int id, input int g, input int l, input int e);
    chk({tag, "_id"},  32'(r_id[k]),  32'(id));
    chk({tag, "_gcd"}, 32'(r_gcd[k]), 32'(g));
    chk({tag, "_lcm"}, 32'(r_lcm[k]), 32'(l));
    chk({tag, "_err"}, 32'(r_err[k]), 32'(e));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_ack"},   32'(req_ack),   32'd0);
    chk({tag, "_start"}, 32'(eng_start), 32'd0);
    chk({tag, "_data"},  32'(eng_data),  32'd0);
    chk({tag, "_vld"},   32'(rsp_valid), 32'd0);
    chk({tag, "_id"},    32'(rsp_id),    32'd0);
    chk({tag, "_gcd"},   32'(rsp_gcd),   32'd0);
    chk({tag, "_lcm"},   32'(rsp_lcm),   32'd0);
    chk({tag, "_err"},   32'(rsp_err),   32'd0);
  endtask

  task automatic do_reset();
    req = '0; req_a = '0; req_b = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge gclk);
    rst_n = 1'b1;
  endtask

  initial begin
    int saw_vld;
    do_reset();
    chk_zero("reset");

    // 1: plain op through the engine
    mode = 0;
    run(4'b0001, 8'd100, 8'd20, 1);
    chk_rsp("t1", 0, 0, 20, 100, 0);
    chk("t1_lat", 32'(r_lat[0]), 32'd4);
    chk("t1_starts", 32'(st_cnt), 32'd1);
    chk("t1_data_a", 32'(d_a), 32'd100);
    chk("t1_data_b", 32'(d_b), 32'd20);

    // 3: zero operand short-circuits the engine
    run(4'b0010, 8'd0, 8'd7, 1);
    chk_rsp("t3", 0, 1, 0, 0, 1);
    chk("t3_lat", 32'(r_lat[0]), 32'd0);
    chk("t3_starts", 32'(st_cnt), 32'd0);

    // 4: silent engine times out, then a normal op recovers
    mode = 1;
    run(4'b0001, 8'd5, 8'd7, 1);
    chk_rsp("t4_to", 0, 0, 0, 0, 1);
    chk("t4_lat", 32'(r_lat[0]), 32'd66);
    mode = 0;
    run(4'b0100, 8'd9, 8'd6, 1);
    chk_rsp("t4_ok", 0, 2, 3, 18, 0);

    // 2: rotating priority from a fresh pointer
    do_reset();
    run(4'b1111, 8'd12, 8'd18, 4);
    for (int k = 0; k < 4; k++) chk_rsp($sformatf("t2_all%0d", k), k, k, 6, 36, 0);
    run(4'b0101, 8'd12, 8'd18, 2);
    chk_rsp("t2_p0", 0, 0, 6, 36, 0);
    chk_rsp("t2_p1", 1, 2, 6, 36, 0);

    // 5: level done; the second op starts with done still high from the first
    mode = 2;
    run(4'b0010, 8'd12, 8'd18, 1);
    chk_rsp("t5_a", 0, 1, 6, 36, 0);
    chk("t5_a_lat", 32'(r_lat[0]), 32'd6);
    run(4'b0001, 8'd15, 8'd10, 1);
    chk_rsp("t5_b", 0, 0, 5, 30, 0);
    chk("t5_b_lat", 32'(r_lat[0]), 32'd6);

    // 6: reset during WAIT drops the op
    mode = 1;
    @(negedge gclk);
    req_a = {NREQ{8'd9}}; req_b = {NREQ{8'd6}}; req = 4'b0100;
    for (int c = 0; c < 6; c++) begin
      @(negedge gclk);
      if (req_ack[2]) req = '0;
    end
    chk("t6_busy_pre", 32'(busy), 32'd1);
    chk("t6_data_pre", 32'(eng_data), 32'd6);
    rst_n = 1'b0;
    #1;
    chk_zero("t6_rst");
    saw_vld = 0;
    repeat (3) begin @(negedge gclk); if (rsp_valid) saw_vld++; end
    chk("t6_no_rsp", 32'(saw_vld), 32'd0);
    rst_n = 1'b1;
    mode = 0;
    run(4'b1000, 8'd8, 8'd12, 1);
    chk_rsp("t6_after", 0, 3, 4, 24, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
